fifo_read_upsizer: RTL and testbench
====================================

Name: fifo_read_upsizer

Overview:
- Drains the read port of an asynchronous FIFO in the read clock domain.
- Packs RATIO consecutive FIFO words into one wide output beat and presents it on a valid/ready stream interface.
- A flush request forces a partially filled beat out, tagged with a word count and a last flag.
- Sits directly on the FIFO read side (empty flag, head data, read strobe), opposite the writer that fills the FIFO.

Parameters:
- WIDTH, 8, FIFO word width in bits.
- RATIO, 4, FIFO words per output beat (≥2).
- CW, $clog2(RATIO)+1, width of the word-count output (derived, not overridden).

Ports:
- clk_in  input  1  read-domain clock; all logic on rising edge.
- nrst_in  input  1  asynchronous active-low reset.
- fifo_empty_in  input  1  FIFO empty flag; head word valid when low.
- fifo_data_in  input  WIDTH  FIFO head word (first-word-fall-through, valid while fifo_empty_in=0).
- fifo_read_out  output  1  pop strobe; one word consumed per cycle high.
- flush_in  input  1  single-cycle request to emit the current partial beat.
- m_data_out  output  WIDTH*RATIO  packed beat; lane k = bits [k*WIDTH +: WIDTH], lane 0 = oldest word.
- m_count_out  output  CW  number of valid lanes in the beat (1..RATIO).
- m_last_out  output  1  beat closed by a flush.
- m_valid_out  output  1  beat valid.
- m_ready_in  input  1  downstream accept.

Behaviour:
- Reset (async, nrst_in=0) clears everything: m_valid_out=0, m_data_out=0, m_count_out=0, m_last_out=0, lane index=0, flush_pend=0, state=COLLECT. fifo_read_out=0 while in reset. Words partially packed at reset are discarded.
- States: COLLECT (filling lanes) and HOLD (beat presented, m_valid_out=1).
- Pop rule: fifo_read_out = !fifo_empty_in && (state==COLLECT || (state==HOLD && m_ready_in)). This path is combinational.
  - fifo_read_out must never assert while fifo_empty_in=1.
- Each pop stores fifo_data_in into lane idx and increments idx.
  - If the pop coincides with a HOLD handshake, the word goes to lane 0 of the fresh beat and idx becomes 1.
- COLLECT → HOLD on a pop into lane RATIO-1:
  - Next cycle m_valid_out=1, m_count_out=RATIO, m_last_out=flush_pend|flush_in, and flush_pend clears.
- Flush:
  - flush_in sets flush_pend; if flush_in arrives during HOLD, it is held for the next COLLECT.
  - In a COLLECT cycle with (flush_pend|flush_in), let n = idx + pop.
    - n=0: clear flush_pend, stay in COLLECT, emit nothing (no empty beats).
    - 0<n<RATIO: go to HOLD with m_count_out=n, m_last_out=1, unused lanes zero.
    - n=RATIO: handled as the full-beat case above with m_last_out=1.
- HOLD:
  - m_data_out, m_count_out and m_last_out are stable until m_valid_out && m_ready_in.
  - On handshake, return to COLLECT, clear lanes to zero, reset idx to 0 (1 if a pop occurred in the same cycle), m_valid_out drops next cycle.
  - The return is skipped if the same-cycle pop completes a beat; only possible when RATIO=1, which is excluded.
- Latency: a beat is valid one cycle after the pop of its last word. Sustained throughput is one beat per RATIO cycles with m_ready_in held high and the FIFO non-empty.
- Lane order is strict FIFO order: no reordering, loss or duplication.

Test Plan:
- Reset, then FIFO preloaded with 0x11,0x22,0x33,0x44, m_ready_in=1 -> four consecutive pops; one cycle after the 4th pop m_data_out=0x44332211, count=4, last=0, valid for one cycle.
- m_ready_in=0 with 8 words 0x01..0x08 queued -> exactly 4 pops, beat 0x04030201 held stable, fifo_read_out=0 during stall. Raising ready -> handshake, same-cycle pop of 0x05, second beat 0x08070605.
- Two words 0xAA,0xBB, then FIFO empty and a flush_in pulse -> beat m_data_out=0x0000BBAA, count=2, last=1; flush_pend cleared afterwards.
- flush_in with idx=0 and FIFO empty -> no beat produced; a later full beat has last=0.
- flush_in pulsed during HOLD (ready=0) -> current beat unchanged; after handshake, the next collected partial data is emitted with last=1 once a word arrives.
- nrst_in asserted mid-collection (idx=2) -> outputs zero immediately; after release the next beat starts at lane 0 with fresh data; fifo_read_out never high while fifo_empty_in=1 (assertion for whole run).

Source files
------------

// File: rtl/fifo_read_upsizer_if.sv
// Read-side bundle for fifo_read_upsizer: FIFO head/pop, flush request and the
// packed output stream. The upsizer connects through the master modport.
interface fifo_read_upsizer_if #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
);
    localparam int CW = $clog2(RATIO) + 1;

    logic                     fifo_empty_in;
    logic [WIDTH-1:0]         fifo_data_in;
    logic                     fifo_read_out;
    logic                     flush_in;
    logic [WIDTH*RATIO-1:0]   m_data_out;
    logic [CW-1:0]            m_count_out;
    logic                     m_last_out;
    logic                     m_valid_out;
    logic                     m_ready_in;

    modport master (
        input  fifo_empty_in,
        input  fifo_data_in,
        input  flush_in,
        input  m_ready_in,
        output fifo_read_out,
        output m_data_out,
        output m_count_out,
        output m_last_out,
        output m_valid_out
    );

    modport slave (
        output fifo_empty_in,
        output fifo_data_in,
        output flush_in,
        output m_ready_in,
        input  fifo_read_out,
        input  m_data_out,
        input  m_count_out,
        input  m_last_out,
        input  m_valid_out
    );
endinterface

// File: rtl/fifo_read_upsizer.sv
// Packs RATIO first-word-fall-through FIFO words into one wide valid/ready beat;
// a flush request closes a partial beat early with a word count and last flag.
module fifo_read_upsizer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                 clk_in,
    input  logic                 nrst_in,
    fifo_read_upsizer_if.master  bus
);
    localparam int CW = $clog2(RATIO) + 1;
    localparam int BW = WIDTH * RATIO;

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    state_t         state;
    logic [CW-1:0]  idx;
    logic [BW-1:0]  acc;
    logic           flush_pend;

    logic [BW-1:0]  m_data;
    logic [CW-1:0]  m_count;
    logic           m_last;
    logic           m_valid;

    logic           pop;
    logic           flush_any;
    logic           last_lane;
    logic [CW-1:0]  n;
    logic [BW-1:0]  acc_pop;

    assign bus.fifo_read_out = pop;
    assign bus.m_data_out    = m_data;
    assign bus.m_count_out   = m_count;
    assign bus.m_last_out    = m_last;
    assign bus.m_valid_out   = m_valid;

    // acc and idx are already zero in HOLD, so a handshake-cycle pop lands in lane 0.
    always_comb begin
        pop       = nrst_in && !bus.fifo_empty_in &&
                    ((state == COLLECT) || bus.m_ready_in);
        flush_any = flush_pend | bus.flush_in;
        n         = idx + CW'(pop);
        last_lane = pop && (idx == CW'(RATIO - 1));
        acc_pop   = acc;
        if (pop) begin
            acc_pop[idx*WIDTH +: WIDTH] = bus.fifo_data_in;
        end
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state      <= COLLECT;
            idx        <= '0;
            acc        <= '0;
            flush_pend <= 1'b0;
            m_data     <= '0;
            m_count    <= '0;
            m_last     <= 1'b0;
            m_valid    <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (last_lane || (flush_any && (n != '0))) begin
                        m_data     <= acc_pop;
                        m_count    <= n;
                        m_last     <= flush_any;
                        m_valid    <= 1'b1;
                        flush_pend <= 1'b0;
                        acc        <= '0;
                        idx        <= '0;
                        state      <= HOLD;
                    end else begin
                        acc <= acc_pop;
                        idx <= n;
                        if (flush_any) begin
                            flush_pend <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (bus.flush_in) begin
                        flush_pend <= 1'b1;
                    end
                    if (bus.m_ready_in) begin
                        m_data  <= '0;
                        m_count <= '0;
                        m_last  <= 1'b0;
                        m_valid <= 1'b0;
                        acc     <= acc_pop;
                        idx     <= n;
                        state   <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_read_upsizer.sv
// Bench for fifo_read_upsizer: queue-backed FIFO, directed scenarios, then random
// traffic compared against a word-list model of beat formation.
module tb_fifo_read_upsizer;
    localparam int WIDTH = 8;
    localparam int RATIO = 4;

    logic clk;
    logic nrst;

    fifo_read_upsizer_if #(.WIDTH(WIDTH), .RATIO(RATIO)) bus ();

    fifo_read_upsizer #(.WIDTH(WIDTH), .RATIO(RATIO)) u_dut (
        .clk_in  (clk),
        .nrst_in (nrst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [7:0]  fifo_q[$];
    logic [7:0]  cur[$];
    logic        held;
    logic [31:0] h_data;
    int          h_count;
    logic        h_last;
    logic        pend;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        check("pop_while_empty", 64'(bus.fifo_read_out & bus.fifo_empty_in), 64'd0);
    end

    task automatic model_reset();
        cur.delete();
        held    = 1'b0;
        h_data  = '0;
        h_count = 0;
        h_last  = 1'b0;
        pend    = 1'b0;
    endtask

    task automatic close_beat(input logic l);
        h_data = '0;
        foreach (cur[i]) h_data = h_data | (32'(cur[i]) << (8 * i));
        h_count = cur.size();
        h_last  = l;
        held    = 1'b1;
        pend    = 1'b0;
        cur.delete();
    endtask

    task automatic model_update(input logic fl, input logic rdy, input logic popped, input logic [7:0] word);
        if (held) begin
            if (fl) pend = 1'b1;
            if (rdy) begin
                held = 1'b0;
                if (popped) cur.push_back(word);
            end
        end else begin
            if (popped) cur.push_back(word);
            if (cur.size() == RATIO) close_beat(pend | fl);
            else if (pend | fl) begin
                if (cur.size() == 0) pend = 1'b0;
                else close_beat(1'b1);
            end
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_empty_in = (fifo_q.size() == 0);
        bus.fifo_data_in  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // Called at a falling edge; returns at the next falling edge after checking outputs.
    task automatic step(input logic fl, input logic rdy);
        logic       exp_pop;
        logic [7:0] word;
        bus.flush_in   = fl;
        bus.m_ready_in = rdy;
        drive_fifo();
        #1;
        exp_pop = (fifo_q.size() != 0) && (!held || rdy);
        check("fifo_read", 64'(bus.fifo_read_out), 64'(exp_pop));
        word = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        @(posedge clk);
        if (exp_pop) void'(fifo_q.pop_front());
        model_update(fl, rdy, exp_pop, word);
        @(negedge clk);
        check("m_valid", 64'(bus.m_valid_out), 64'(held));
        if (held) begin
            check("m_data", 64'(bus.m_data_out), 64'(h_data));
            check("m_count", 64'(bus.m_count_out), 64'(h_count));
            check("m_last", 64'(bus.m_last_out), 64'(h_last));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 64'(bus.m_valid_out), 64'd0);
        check({tag, "_data"},  64'(bus.m_data_out),  64'd0);
        check({tag, "_count"}, 64'(bus.m_count_out), 64'd0);
        check({tag, "_last"},  64'(bus.m_last_out),  64'd0);
        check({tag, "_pop"},   64'(bus.fifo_read_out), 64'd0);
    endtask

    task automatic check_beat(input string tag, input logic [31:0] d, input int c, input logic l);
        check({tag, "_valid"}, 64'(bus.m_valid_out), 64'd1);
        check({tag, "_data"},  64'(bus.m_data_out),  64'(d));
        check({tag, "_count"}, 64'(bus.m_count_out), 64'(c));
        check({tag, "_last"},  64'(bus.m_last_out),  64'(l));
    endtask

    initial begin
        nrst = 1'b0;
        bus.flush_in   = 1'b0;
        bus.m_ready_in = 1'b0;
        fifo_q.push_back(8'hEE);
        drive_fifo();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        nrst = 1'b1;
        fifo_q.delete();

        // Full beat with ready high
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        repeat (4) step(1'b0, 1'b1);
        check_beat("beat1", 32'h44332211, 4, 1'b0);
        step(1'b0, 1'b1);
        check("beat1_drop", 64'(bus.m_valid_out), 64'd0);

        // Back-pressure, then handshake with same-cycle pop
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
        repeat (6) step(1'b0, 1'b0);
        check_beat("stall", 32'h04030201, 4, 1'b0);
        check("stall_left", 64'(fifo_q.size()), 64'd4);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        check_beat("beat2", 32'h08070605, 4, 1'b0);
        step(1'b0, 1'b1);

        // Partial flush
        fifo_q = '{8'hAA, 8'hBB};
        repeat (2) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check_beat("partial", 32'h0000BBAA, 2, 1'b1);
        step(1'b0, 1'b1);

        // Flush with nothing collected emits no beat
        step(1'b1, 1'b1);
        check("empty_flush", 64'(bus.m_valid_out), 64'd0);
        fifo_q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        repeat (4) step(1'b0, 1'b1);
        check_beat("after_empty_flush", 32'hD4D3D2D1, 4, 1'b0);
        step(1'b0, 1'b1);

        // Flush during HOLD carries over to the next collection
        fifo_q = '{8'h61, 8'h62, 8'h63, 8'h64};
        repeat (4) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check_beat("hold_flush", 32'h64636261, 4, 1'b0);
        step(1'b0, 1'b1);
        check("hold_flush_drop", 64'(bus.m_valid_out), 64'd0);
        fifo_q.push_back(8'h5A);
        step(1'b0, 1'b1);
        check_beat("carried_flush", 32'h0000005A, 1, 1'b1);
        step(1'b0, 1'b1);

        // Reset mid-collection
        fifo_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        repeat (2) step(1'b0, 1'b1);
        drive_fifo();
        nrst = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        fifo_q.push_back(8'hC6);
        repeat (4) step(1'b0, 1'b1);
        check_beat("post_reset", 32'hC6C5C4C3, 4, 1'b0);
        step(1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (($urandom_range(0, 3) != 0) && (fifo_q.size() < 16))
                fifo_q.push_back(8'($urandom));
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
